control_fsm: RTL
================

# control_fsm

Multi-cycle control sequencer for the lucknow RV32I core. It fetches, decodes, executes and retires one instruction at a time. It drives the sign extender's `imm_op`, plus the ALU, register-file, PC/IR write enables and the instruction/data memory handshakes. It sits between the IR and the datapath and is the only block that advances the PC.

## Interface
- `DATA_WIDTH`, default 32: datapath width; the block passes it through to the datapath and does not use it internally.
- `TIMEOUT`, default 16: maximum consecutive wait cycles allowed on a memory request before the block traps.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `inst`  in  32: current IR contents, valid from DECODE onward.
- `imem_req`  out  1: instruction fetch request.
- `imem_ready`  in  1: fetch data valid; the handshake completes when `imem_req` and `imem_ready` are both high.
- `dmem_req`  out  1: data access request.
- `dmem_we`  out  1: data access is a store.
- `dmem_ready`  in  1: data access complete.
- `ir_we`  out  1: latch fetched word into the IR.
- `pc_we`  out  1: PC <= PC+4.
- `imm_op`  out  3: 3'b000 selects I-type (inst[31:20]); 3'b001 selects S-type ({inst[31:25],inst[11:7]}).
- `alu_op`  out  4: {sub/arith bit, funct3}.
- `alu_src_imm`  out  1: ALU operand B comes from the sign extender.
- `reg_we`  out  1: register-file write.
- `wb_sel`  out  1: writeback source; 0 = ALU, 1 = load data.
- `busy`  out  1: high in every state except IDLE and TRAP.
- `trap`  out  1: sticky fault indicator.
- `trap_cause`  out  2: 00 none, 01 imem timeout, 10 dmem timeout, 11 illegal instruction.

## Operation
- States are IDLE, FETCH, DECODE, EXECUTE, MEM, WB and TRAP. Reset forces the state to IDLE and clears the decode register and wait counter.
- **IDLE:** all outputs are 0. The block moves to FETCH on the next cycle.
- **FETCH:** `imem_req` is held high. On `imem_ready`, `ir_we` is high for that cycle and the state moves to DECODE.
- **DECODE:** the block classifies `inst[6:0]` and registers `imm_op`, `alu_op`, `alu_src_imm`, `wb_sel` and the class.
  - 0000011 with funct3=010 is LW: `imm_op` 000, `alu_op` 0000, `alu_src_imm` 1, `wb_sel` 1.
  - 0100011 with funct3=010 is SW: `imm_op` 001, `alu_op` 0000, `alu_src_imm` 1.
  - 0010011 is OP-IMM: `imm_op` 000, `alu_src_imm` 1, `alu_op` = {funct3==101 ? inst[30] : 0, funct3}.
  - 0110011 is OP: `alu_src_imm` 0, `alu_op` = {inst[30], funct3}.
  - Any other encoding is illegal; see Configuration.
- **EXECUTE:** one cycle with the ALU controls valid. LW and SW move to MEM; OP and OP-IMM move to WB.
- **MEM:** `dmem_req` is held high, and `dmem_we` = 1 for SW.
  - On `dmem_ready`, LW moves to WB.
  - On `dmem_ready`, SW asserts `pc_we` for that cycle and moves to FETCH.
- **WB:** `reg_we`=1 and `pc_we`=1 for one cycle, then the state moves to FETCH.
- **TRAP:** all outputs are 0 except `trap`=1 and `trap_cause`. Only reset leaves TRAP.
- **Wait counter:** width is clog2(TIMEOUT+1). It is cleared on entry to FETCH or MEM and increments on each cycle where the request is high and ready is low.
  - If the counter equals TIMEOUT-1 and ready is low, the next state is TRAP with cause 01 (FETCH) or 10 (MEM).
  - Ready always wins when it arrives in the same cycle as a timeout.
- Decoded fields stay stable from DECODE until the next FETCH.

## Timing
- Latency with zero-wait memory (ready in the first request cycle):
  - OP/OP-IMM: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
- Each memory wait cycle adds 1 cycle.
- The request/ready handshake completes in any of the first TIMEOUT request cycles. The block traps on cycle TIMEOUT+1.
- `ir_we`, `pc_we` and the memory-ready-dependent outputs are combinational in the ready input. All other outputs are decoded from registered state.
- **Reset mid-operation:** `rst_n` low sampled at an edge puts the block in IDLE at that edge. Any pending `imem_req`/`dmem_req` drops that cycle, and no `pc_we` or `reg_we` is issued.
- Reset values: every output is 0, including `trap_cause`=00.

## Configuration
- **`CTRL_ILLEGAL_TRAP_EN` defined:** an illegal encoding, or LW/SW with funct3≠010, moves DECODE to TRAP with cause 11.
- **`CTRL_ILLEGAL_TRAP_EN` undefined:** such instructions retire as a NOP via DECODE → WB with `reg_we`=0 and `pc_we`=1. `trap_cause` 11 never occurs.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles, then release -> all outputs are 0 during reset and in IDLE; `imem_req`=1 on the second cycle after release.
- ADDI 0x00500093, then SUB 0x40208033, zero-wait -> ADDI gives `ir_we` in cycle 1, `imm_op`=000, `alu_src_imm`=1, `alu_op`=0000, and `reg_we`=`pc_we`=1 with `wb_sel`=0 in cycle 4. SUB gives `alu_op`=1000 and `alu_src_imm`=0.
- LW 0x0080A103 with `dmem_ready` delayed 3 cycles -> `dmem_req` is high for 4 cycles, then WB with `wb_sel`=1 and `reg_we`=1. Total latency is 8 cycles.
- SW 0x0020A423, zero-wait -> `imm_op`=001 and `dmem_we`=1. `pc_we` fires in the `dmem_ready` cycle and `reg_we` never asserts.
- `imem_ready` tied 0 -> `imem_req` is high for 16 cycles, then `trap`=1 with `trap_cause`=01. Both stay sticky until reset, and `busy`=0. Ready arriving in cycle 16 instead completes the fetch normally.
- `inst`=0x0000007F -> with `CTRL_ILLEGAL_TRAP_EN`, TRAP with cause 11 after DECODE; without it, WB with `pc_we`=1 and `reg_we`=0, then FETCH.

Source files
------------

// File: rtl/control_fsm.sv
// control_fsm: multi-cycle fetch/decode/execute/retire sequencer for the lucknow RV32I core.
// Build option: define CTRL_ILLEGAL_TRAP_EN to trap on illegal encodings instead of retiring them as NOPs.
module control_fsm #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst,
  output logic        imem_req,
  input  logic        imem_ready,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  output logic        ir_we,
  output logic        pc_we,
  output logic [2:0]  imm_op,
  output logic [3:0]  alu_op,
  output logic        alu_src_imm,
  output logic        reg_we,
  output logic        wb_sel,
  output logic        busy,
  output logic        trap,
  output logic [1:0]  trap_cause
);

  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam int               unused_data_width = DATA_WIDTH;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_IMEM    = 2'b01;
  localparam logic [1:0] CAUSE_DMEM    = 2'b10;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b11;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WB,
    S_TRAP
  } state_t;

  typedef enum logic [2:0] {
    C_NONE,
    C_LW,
    C_SW,
    C_OP,
    C_OPIMM,
    C_ILLEGAL
  } class_t;

  state_t           state;
  state_t           next_state;
  class_t           cls_q;
  class_t           dec_cls;
  logic [2:0]       imm_op_q;
  logic [3:0]       alu_op_q;
  logic             alu_src_q;
  logic             wb_sel_q;
  logic [2:0]       dec_imm;
  logic [3:0]       dec_alu;
  logic             dec_src;
  logic             dec_wbs;
  logic [CNT_W-1:0] wait_cnt;
  logic [1:0]       cause_q;
  logic [1:0]       next_cause;
  logic             ir_we_c;
  logic             pc_we_c;
  logic             reg_we_c;
  logic [2:0]       funct3;
  logic             unused_inst_bits;

  assign funct3           = inst[14:12];
  assign unused_inst_bits = ^{inst[31], inst[29:15], inst[11:7]};

  // Instruction classification straight from the IR; only sampled while in DECODE.
  always_comb begin
    dec_cls = C_ILLEGAL;
    dec_imm = IMM_I;
    dec_alu = 4'b0000;
    dec_src = 1'b0;
    dec_wbs = 1'b0;
    case (inst[6:0])
      OPC_LOAD: begin
        if (funct3 == 3'b010) begin
          dec_cls = C_LW;
          dec_src = 1'b1;
          dec_wbs = 1'b1;
        end
      end
      OPC_STORE: begin
        if (funct3 == 3'b010) begin
          dec_cls = C_SW;
          dec_imm = IMM_S;
          dec_src = 1'b1;
        end
      end
      OPC_OPIMM: begin
        dec_cls = C_OPIMM;
        dec_src = 1'b1;
        dec_alu = {(funct3 == 3'b101) & inst[30], funct3};
      end
      OPC_OP: begin
        dec_cls = C_OP;
        dec_alu = {inst[30], funct3};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cause_q <= CAUSE_NONE;
    end else begin
      state   <= next_state;
      cause_q <= next_cause;
    end
  end

  // Decoded fields are captured once per instruction and held until the next DECODE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cls_q     <= C_NONE;
      imm_op_q  <= 3'b000;
      alu_op_q  <= 4'b0000;
      alu_src_q <= 1'b0;
      wb_sel_q  <= 1'b0;
    end else if (state == S_DECODE) begin
      cls_q     <= dec_cls;
      imm_op_q  <= dec_imm;
      alu_op_q  <= dec_alu;
      alu_src_q <= dec_src;
      wb_sel_q  <= dec_wbs;
    end
  end

  // Restarting on any state change gives each FETCH/MEM visit a fresh timeout budget.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (next_state != state) begin
      wait_cnt <= '0;
    end else if ((imem_req && !imem_ready) || (dmem_req && !dmem_ready)) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    next_cause = cause_q;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    ir_we_c    = 1'b0;
    pc_we_c    = 1'b0;
    reg_we_c   = 1'b0;
    case (state)
      S_IDLE: begin
        next_state = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we_c    = 1'b1;
          next_state = S_DECODE;
        end else if (wait_cnt == CNT_LAST) begin
          next_state = S_TRAP;
          next_cause = CAUSE_IMEM;
        end
      end
      S_DECODE: begin
        case (dec_cls)
          C_LW, C_SW, C_OP, C_OPIMM: next_state = S_EXECUTE;
          default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            next_state = S_TRAP;
            next_cause = CAUSE_ILLEGAL;
`else
            next_state = S_WB;
`endif
          end
        endcase
      end
      S_EXECUTE: begin
        if (cls_q == C_LW || cls_q == C_SW) begin
          next_state = S_MEM;
        end else begin
          next_state = S_WB;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls_q == C_SW);
        if (dmem_ready) begin
          if (cls_q == C_SW) begin
            pc_we_c    = 1'b1;
            next_state = S_FETCH;
          end else begin
            next_state = S_WB;
          end
        end else if (wait_cnt == CNT_LAST) begin
          next_state = S_TRAP;
          next_cause = CAUSE_DMEM;
        end
      end
      S_WB: begin
        pc_we_c    = 1'b1;
        reg_we_c   = (cls_q == C_LW) || (cls_q == C_OP) || (cls_q == C_OPIMM);
        next_state = S_FETCH;
      end
      S_TRAP: begin
        next_state = S_TRAP;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // DECODE shows the live classification; later states show the captured copy.
  always_comb begin
    imm_op      = 3'b000;
    alu_op      = 4'b0000;
    alu_src_imm = 1'b0;
    wb_sel      = 1'b0;
    case (state)
      S_DECODE: begin
        imm_op      = dec_imm;
        alu_op      = dec_alu;
        alu_src_imm = dec_src;
        wb_sel      = dec_wbs;
      end
      S_FETCH, S_EXECUTE, S_MEM, S_WB: begin
        imm_op      = imm_op_q;
        alu_op      = alu_op_q;
        alu_src_imm = alu_src_q;
        wb_sel      = wb_sel_q;
      end
      default: ;
    endcase
  end

  // Commit strobes are suppressed while reset is asserted so an interrupted instruction never retires.
  assign ir_we      = ir_we_c & rst_n;
  assign pc_we      = pc_we_c & rst_n;
  assign reg_we     = reg_we_c & rst_n;
  assign busy       = (state != S_IDLE) && (state != S_TRAP);
  assign trap       = (state == S_TRAP);
  assign trap_cause = cause_q;

endmodule
